cntr_mod: RTL
=============

CNTR_MOD -- requirements
Module: cntr_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and load width in bits (1..32).
REQ-002 SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port aclr, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port en, input, 1, count enable; gates func 00/01 only.
REQ-006 SHALL have port func, input, 2, operation: 00 up, 01 down, 10 load, 11 hold.
REQ-007 SHALL have port load, input, WIDTH, parallel load value.
REQ-008 SHALL have port set_max, input, 1, synchronous preset to MODULUS-1.
REQ-009 SHALL have port q, output, WIDTH, registered count.
REQ-010 SHALL have port tc, output, 1, terminal count, combinational from q, func and en.
REQ-011 SHALL have port evt, output, 1, registered one-cycle boundary-event pulse.

Function
REQ-012 SHALL apply priority per edge: aclr > set_max > func.
REQ-013 SHALL, for set_max=1, load q=MODULUS-1 and clear evt.
REQ-014 SHALL, for func=00 with en=1, step q up by 1; at q=MODULUS-1, apply the boundary rule (REQ-024/025).
REQ-015 SHALL, for func=01 with en=1, step q down by 1; at q=0, apply the boundary rule.
REQ-016 SHALL, for func=00 or 01 with en=0, hold q.
REQ-017 SHALL, for func=10, load q=load regardless of en; load>=MODULUS is clamped to MODULUS-1.
REQ-018 SHALL, for func=11, hold q regardless of en.
REQ-019 SHALL drive tc=1 iff en=1 and either func=00 with q=MODULUS-1, or func=01 with q=0; otherwise tc=0.
REQ-020 SHALL assert evt for exactly the one cycle after an edge on which tc was 1 and no higher-priority aclr or set_max was present.
REQ-021 SHALL hold evt at 0 after load, hold and preset edges.
REQ-022 SHALL keep q within 0..MODULUS-1 at all times after the first reset.
REQ-023 SHALL make an up or down step visible on q one clock after the edge (latency 1); tc is combinational, with zero latency.

Reset
REQ-026 SHALL, on aclr=1 at a rising clk edge, set q=0 and evt=0, overriding set_max, func and en.
REQ-027 SHALL give aclr immediate effect mid-count; counting resumes on the first edge with aclr=0.
REQ-028 SHALL leave q undefined before the first reset; no initial blocks and no simulation-control statements in the RTL.

Configuration
REQ-024 SHALL, with macro CNTR_SAT_EN undefined, wrap: up at MODULUS-1 gives 0; down at 0 gives MODULUS-1.
REQ-025 SHALL, with macro CNTR_SAT_EN defined, saturate: up at MODULUS-1 holds MODULUS-1; down at 0 holds 0; tc and evt behave identically in both builds.

Verification
REQ-029 SHALL cover, with MODULUS=10 and no macro: aclr, then func=00, en=1 for 12 edges -> q 1..9,0,1,2; tc=1 while q=9; evt high exactly the cycle q=0.
REQ-030 SHALL cover, with MODULUS=10 and CNTR_SAT_EN defined: from q=8, func=00 for 3 edges -> q 9,9,9; evt pulses after edges 2 and 3.
REQ-031 SHALL cover, with MODULUS=10: func=01 from q=0 -> q=9 in the wrap build, q=0 in the saturate build; evt=1 next cycle in both.
REQ-032 SHALL cover, with MODULUS=10: func=10 with load=8'd7 -> q=7; load=8'd200 -> q=9; en=0 does not block either load.
REQ-033 SHALL cover: aclr=1 and set_max=1 on the same edge -> q=0; set_max alone -> q=MODULUS-1; aclr asserted mid-count at q=5 -> q=0 on that edge, evt=0.
REQ-034 SHALL cover, with WIDTH=8, MODULUS=256: up from 255 -> q=0 (wrap build), tc=1 at 255; en=0 with func=00 for 5 edges -> q unchanged, tc=0.

Source files
------------

// File: rtl/cntr_mod.sv
// Modulo-MODULUS up/down counter with parallel load, preset, terminal count and event pulse.
// Define CNTR_SAT_EN to saturate at the count limits instead of wrapping.
module cntr_mod #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 10
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             en,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] load,
  input  logic             set_max,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt
);

  localparam logic [1:0] FUNC_UP   = 2'b00;
  localparam logic [1:0] FUNC_DOWN = 2'b01;
  localparam logic [1:0] FUNC_LOAD = 2'b10;

  // MOD_EXT is one bit wider so MODULUS = 2^WIDTH is representable for the clamp compare.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

`ifdef CNTR_SAT_EN
  localparam logic [WIDTH-1:0] UP_LIMIT_Q   = MAX_Q;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_Q = '0;
`else
  localparam logic [WIDTH-1:0] UP_LIMIT_Q   = '0;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_Q = MAX_Q;
`endif

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_step;

  assign at_max       = (q == MAX_Q);
  assign at_zero      = (q == '0);
  assign load_clamped = ({1'b0, load} >= MOD_EXT) ? MAX_Q : load;

  assign tc = en & (((func == FUNC_UP) & at_max) | ((func == FUNC_DOWN) & at_zero));

  always_comb begin
    q_step = q;
    case (func)
      FUNC_UP: begin
        if (en) q_step = at_max ? UP_LIMIT_Q : q + WIDTH'(1);
      end
      FUNC_DOWN: begin
        if (en) q_step = at_zero ? DOWN_LIMIT_Q : q - WIDTH'(1);
      end
      FUNC_LOAD: q_step = load_clamped;
      default:   q_step = q;
    endcase
  end

  // evt follows tc only on edges that actually performed a count step.
  always_ff @(posedge clk) begin
    if (aclr) begin
      q   <= '0;
      evt <= 1'b0;
    end else if (set_max) begin
      q   <= MAX_Q;
      evt <= 1'b0;
    end else begin
      q   <= q_step;
      evt <= tc;
    end
  end

endmodule
